// File: rtl/mips_result_checker.sv
// Self-checking monitor for the MIPS ALUResult stream: loads a queue of expected
// results, compares observations in order, and reports pass/fail with error details.
module mips_result_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 8
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       exp_valid,
  input  logic [WIDTH-1:0]           exp_data,
  output logic                       exp_ready,
  input  logic                       obs_valid,
  input  logic [WIDTH-1:0]           obs_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [ERR_W-1:0]           err_count,
  output logic [$clog2(DEPTH+1)-1:0] match_count,
  output logic [$clog2(DEPTH+1)-1:0] first_err_idx,
  output logic [WIDTH-1:0]           first_err_obs
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TMAX    = TW'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [CW-1:0]     match_q, match_d, fidx_q, fidx_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [WIDTH-1:0]  fobs_q, fobs_d;
  logic              to_q, to_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              full, empty, push;
  logic [WIDTH-1:0]  head;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
  assign push  = (state_q == S_IDLE) && exp_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tmr_d    = tmr_q;
    match_d  = match_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fobs_d   = fobs_q;
    to_d     = to_q;
    case (state_q)
      S_IDLE: begin
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (start) begin
          tmr_d   = '0;
          state_d = empty ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (obs_valid) begin
          tmr_d    = '0;
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (obs_data == head) begin
            match_d = match_q + CW'(1);
          end else begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            // Pointers restart at 0 each run, so the read pointer is the compare index.
            if (err_q == '0) begin
              fidx_d = CW'(rd_ptr_q);
              fobs_d = obs_data;
            end
          end
          if (rd_ptr_q + PW'(1) == wr_ptr_q) begin
            state_d  = S_DONE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end
        end else if (tmr_q == TMAX) begin
          state_d  = S_DONE;
          to_d     = 1'b1;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DONE: begin
        if (clear) begin
          state_d = S_IDLE;
          match_d = '0;
          err_d   = '0;
          fidx_d  = '0;
          fobs_d  = '0;
          to_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tmr_q    <= '0;
      match_q  <= '0;
      err_q    <= '0;
      fidx_q   <= '0;
      fobs_q   <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tmr_q    <= tmr_d;
      match_q  <= match_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fobs_q   <= fobs_d;
      to_q     <= to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= exp_data;
  end

  assign exp_ready     = (state_q == S_IDLE) && !full;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_q == '0) && !to_q;
  assign fail          = done && !pass;
  assign timeout       = to_q;
  assign err_count     = err_q;
  assign match_count   = match_q;
  assign first_err_idx = fidx_q;
  assign first_err_obs = fobs_q;

endmodule

// File: tb/tb_mips_result_checker.sv
// Randomized and directed bench for mips_result_checker against a queue-level
// reference model of the expected results.
module tb_mips_result_checker;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int ERR_W   = 3;
  localparam int CW      = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             Reset, start, clear, exp_valid, obs_valid;
  logic [WIDTH-1:0] exp_data, obs_data;
  logic             exp_ready, busy, done, pass, fail, timeout;
  logic [ERR_W-1:0] err_count;
  logic [CW-1:0]    match_count, first_err_idx;
  logic [WIDTH-1:0] first_err_obs;

  mips_result_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .Reset(Reset), .start(start), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .obs_valid(obs_valid), .obs_data(obs_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_count(err_count), .match_count(match_count),
    .first_err_idx(first_err_idx), .first_err_obs(first_err_obs)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [WIDTH-1:0] ev [DEPTH];
  logic [WIDTH-1:0] ov [DEPTH];
  int               gp [DEPTH];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      exp_valid = 1'b1;
      exp_data  = ev[i];
      tick();
    end
    exp_valid = 1'b0;
  endtask

  // Reference: first k observations compared in order against the loaded list.
  task automatic expect_results(input int k, input bit timed);
    int               m, e, fi;
    logic [WIDTH-1:0] fo;
    bit               seen, ps;
    m = 0; e = 0; fi = 0; fo = '0; seen = 0;
    for (int i = 0; i < k; i++) begin
      if (ov[i] == ev[i]) m++;
      else begin
        if (!seen) begin seen = 1; fi = i; fo = ov[i]; end
        e++;
      end
    end
    if (e > (1 << ERR_W) - 1) e = (1 << ERR_W) - 1;
    ps = (e == 0) && !timed;
    check_eq("done", done, 1);
    check_eq("busy_in_done", busy, 0);
    check_eq("timeout", timeout, timed);
    check_eq("pass", pass, ps);
    check_eq("fail", fail, !ps);
    check_eq("match_count", match_count, m);
    check_eq("err_count", err_count, e);
    check_eq("first_err_idx", first_err_idx, fi);
    check_eq("first_err_obs", first_err_obs, fo);
  endtask

  task automatic run_after_load(input int n, input int k, input bit noise);
    check_eq("ready_after_load", exp_ready, n < DEPTH);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      expect_results(0, 0);
    end else begin
      check_eq("busy_after_start", busy, 1);
      for (int i = 0; i < k; i++) begin
        for (int g = 0; g < gp[i]; g++) begin
          if (noise) begin
            start     = 1'($urandom % 2);
            exp_valid = 1'($urandom % 2);
            exp_data  = $urandom;
            obs_data  = $urandom;
          end
          tick();
        end
        start     = 1'b0;
        exp_valid = 1'b0;
        obs_valid = 1'b1;
        obs_data  = ov[i];
        tick();
        obs_valid = 1'b0;
      end
      if (k < n) begin
        repeat (TIMEOUT - 1) tick();
        check_eq("no_early_timeout", done, 0);
        tick();
        expect_results(k, 1);
      end else begin
        expect_results(k, 0);
      end
    end
    // Results must hold in DONE regardless of stray inputs.
    obs_valid = 1'b1; obs_data = $urandom; start = 1'b1; exp_valid = 1'b1;
    tick();
    obs_valid = 1'b0; start = 1'b0; exp_valid = 1'b0;
    expect_results(k, (n != 0) && (k < n));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clear_done", done, 0);
    check_eq("clear_ready", exp_ready, 1);
    check_eq("clear_match", match_count, 0);
    check_eq("clear_err", err_count, 0);
    check_eq("clear_timeout", timeout, 0);
    check_eq("clear_fidx", first_err_idx, 0);
  endtask

  task automatic run_case(input int n, input int k, input bit noise);
    load(n);
    run_after_load(n, k, noise);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] xv;
    int n, k;
    Reset = 1'b1; start = 0; clear = 0; exp_valid = 0; obs_valid = 0;
    exp_data = '0; obs_data = '0;
    tick(); tick();
    Reset = 1'b0;

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_fail", fail, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_err", err_count, 0);
    check_eq("rst_match", match_count, 0);
    check_eq("rst_fidx", first_err_idx, 0);
    check_eq("rst_fobs", first_err_obs, 0);
    check_eq("rst_ready", exp_ready, 1);

    // Clean run
    ev[0] = 32'h5; ev[1] = 32'hA; ev[2] = 32'hFFFF_FFFF; ev[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin ov[i] = ev[i]; gp[i] = 0; end
    run_case(4, 4, 0);

    // Mismatch then stop observing
    ev[0] = 32'h5; ev[1] = 32'h6; ev[2] = 32'h9;
    ov[0] = 32'h5; ov[1] = 32'h7; ov[2] = 32'h9;
    for (int i = 0; i < 3; i++) gp[i] = 0;
    run_case(3, 3, 0);

    // Timeout with a full queue, two observations
    for (int i = 0; i < DEPTH; i++) begin ev[i] = $urandom; ov[i] = ev[i]; gp[i] = 0; end
    run_case(DEPTH, 2, 0);

    // Full queue, dropped 17th push, obs ignored in IDLE, start ignored in RUN
    for (int i = 0; i < DEPTH; i++) begin ev[i] = 32'h100 + i; ov[i] = ev[i]; gp[i] = 1; end
    for (int i = 0; i <= DEPTH; i++) begin
      check_eq("ready_during_fill", exp_ready, i < DEPTH);
      exp_valid = 1'b1;
      exp_data  = (i < DEPTH) ? ev[i] : 32'hDEAD_BEEF;
      tick();
    end
    exp_valid = 1'b0;
    obs_valid = 1'b1; obs_data = 32'h100;
    tick(); tick();
    obs_valid = 1'b0;
    check_eq("idle_obs_match", match_count, 0);
    check_eq("idle_obs_err", err_count, 0);
    check_eq("idle_obs_busy", busy, 0);
    run_after_load(DEPTH, DEPTH, 1);

    // Error counter saturation
    for (int i = 0; i < DEPTH; i++) begin ev[i] = i; ov[i] = ~ev[i]; gp[i] = 0; end
    run_case(DEPTH, DEPTH, 0);

    // Reset mid-run
    for (int i = 0; i < 4; i++) begin ev[i] = 32'h40 + i; ov[i] = ev[i]; gp[i] = 0; end
    load(4);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obs_valid = 1'b1; obs_data = ov[i]; tick();
    end
    obs_valid = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_match", match_count, 0);
    check_eq("midrst_ready", exp_ready, 1);
    run_case(0, 0, 0);
    ev[0] = 32'h1234_5678; ov[0] = ev[0]; gp[0] = 0;
    run_case(1, 1, 0);

    // Randomized runs
    for (int t = 0; t < 20; t++) begin
      n = 1 + ($urandom % DEPTH);
      k = (($urandom % 4) == 0) ? ($urandom % n) : n;
      for (int i = 0; i < n; i++) begin
        ev[i] = $urandom;
        xv    = ev[i] ^ (32'h1 << ($urandom % 32));
        ov[i] = (($urandom % 3) == 0) ? xv : ev[i];
        gp[i] = $urandom % 4;
      end
      run_case(n, k, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_result_checker.md
# mips_result_checker

On-chip self-checking monitor for the single-cycle MIPS core's ALUResult stream: a parametrised, synthesizable successor to the free-running waveform bench. Before a run, a queue of expected ALU results is loaded. After `start`, each observed result is compared in order against the queue head. The block ends the run on queue exhaustion or on a stall timeout, and reports pass/fail, match and error counts, and the first failing index and value. It sits beside `MIPS` on the same clock and taps `ALUResult` through `obs_valid`/`obs_data`.

## Interface
Parameters:
- WIDTH, 32, data width of expected and observed results
- DEPTH, 16, expected-value queue depth; power of two, ≥2
- TIMEOUT, 64, maximum idle cycles allowed in RUN with no `obs_valid`; ≥2
- ERR_W, 8, width of `err_count`; the count saturates

Ports:
- clk  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high; clears all state
- start  in  1  pulse; begins a run; honoured only in IDLE
- clear  in  1  pulse; DONE→IDLE and clears results; ignored in other states
- exp_valid  in  1  expected value offered
- exp_data  in  WIDTH  expected value
- exp_ready  out  1  queue accepts a value; equals (state==IDLE && !full)
- obs_valid  in  1  observed result present this cycle
- obs_data  in  WIDTH  observed result (MIPS ALUResult)
- busy  out  1  state==RUN
- done  out  1  state==DONE
- pass  out  1  done && err_count==0 && !timeout
- fail  out  1  done && !pass
- timeout  out  1  run ended by stall timer
- err_count  out  ERR_W  mismatches plus unexpected observations; saturating
- match_count  out  $clog2(DEPTH+1)  successful compares
- first_err_idx  out  $clog2(DEPTH+1)  0-based compare index of the first error
- first_err_obs  out  WIDTH  `obs_data` at the first error

## Operation
- States: IDLE, RUN, DONE. Every output, every counter, and the queue pointers reset to 0. The state resets to IDLE.
- IDLE: a push occurs when `exp_valid && exp_ready`. `obs_valid` is ignored.
- IDLE→RUN on `start`. If the queue is empty at `start`, the block goes IDLE→DONE directly; `pass` is then 1.
- RUN: `exp_ready`=0 and pushes are ignored. On each `obs_valid`:
  - Queue non-empty: compare `obs_data` against the head and pop. On equality, `match_count`++. Otherwise `err_count`++.
  - Queue empty: not possible in RUN; see the exit rule below.
- RUN→DONE on the same edge that pops the last entry, so the queue is empty on entering DONE.
- Stall timer:
  - Cleared on entry to RUN and on every `obs_valid`. Increments otherwise.
  - When it reaches TIMEOUT-1 with no `obs_valid` that cycle, the block goes RUN→DONE, sets `timeout`=1, and flushes the remaining queue entries (pointers reset).
- First error: on the first compare with `err_count`==0 that mismatches, capture `first_err_idx` = compare index (the number of compares before it) and `first_err_obs`. Later errors do not overwrite these.
- `err_count` saturates at 2^ERR_W-1 and never wraps.
- DONE: all outputs are held. `obs_valid`, `exp_valid` and `start` are ignored. `clear` clears the counters, the first-error registers and `timeout`, and the block goes to IDLE.
- Reset in any state, including mid-RUN, returns the block to reset values on the next edge and empties the queue. Reset has priority over `start`, `clear`, `obs_valid` and `exp_valid`.
- Queue full: `exp_ready`=0; `exp_valid` is ignored without error.

## Timing
- Push: a push at edge N is visible in the occupancy at N+1.
- Compare latency: `obs_valid` sampled at edge N updates the counters and first-error registers after edge N. There is no combinational path from `obs_*` to any output.
- The last pop and the DONE transition occur on the same edge. `done`/`pass`/`fail` are valid the cycle after the final `obs_valid`.
- Timeout: with the last `obs_valid` at edge N (or RUN entered at edge N), `done`=`timeout`=1 after edge N+TIMEOUT.
- `start` at edge N: `busy`=1 after N.
- `clear` at edge N: IDLE and zeroed results after N.
- Throughput: one compare per cycle when `obs_valid` is continuously high.

## Test plan
- Reset behaviour: assert Reset for 2 cycles. Required: all outputs are 0, `exp_ready`=1, and the block is in IDLE.
- Clean run: load 4 values 0x5, 0xA, 0xFFFFFFFF, 0x0, then `start`, then 4 back-to-back matching `obs_valid`. Required:
  - `done`=1 the cycle after the 4th observation.
  - `pass`=1, `match_count`=4, `err_count`=0.
- Mismatch and stall: load 3 values, then observe 0x5, 0x7 (expected 0x6), 0x9, then stop observing. Required: `first_err_idx`=1, `first_err_obs`=0x7, `err_count`=1, `match_count`=2, `fail`=1, `timeout`=0.
- Timeout path: load DEPTH=16 values, `start`, observe 2, then hold `obs_valid`=0. Required:
  - `done`=`timeout`=`fail`=1 exactly TIMEOUT cycles after the 2nd observation.
  - The queue is flushed; after `clear`, `exp_ready`=1.
- Full and ignore rules: push 17 values. Required:
  - `exp_ready` drops after the 16th and the 17th push is dropped.
  - `obs_valid` in IDLE leaves the counters at 0.
  - A `start` pulse while in RUN is ignored.
- Reset mid-run: Reset after 2 of 4 compares. Required: the next cycle shows IDLE, zeroed counters and an empty queue. A new load/run of 1 matching value then gives `pass`=1.
